ctrl_decode_reg: RTL
====================

Name: ctrl_decode_reg

Overview:
- Next-generation main control decoder for the pipelined RV32I core: decodes the opcode and registers the control bundle into a one-entry ID/EX control register with valid/ready handshake, flush and illegal-opcode detection.
- Extends the current opcode set with jalr and auipc (both parameter-enabled) and widens ALUSrcA to 2 bits.
- Sits between the ID-stage instruction register and the EX stage.
- The hazard unit drives the flush and the downstream back-pressure.

Parameters:
- XLEN, 32, width of the PC passed alongside the instruction.
- EN_JALR, 1, when 1 opcode 1100111 is legal; when 0 it is illegal.
- EN_AUIPC, 1, when 1 opcode 0010111 is legal; when 0 it is illegal.
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID stage presents an instruction
- in_ready  out  1  block accepts this cycle
- instr  in  32  instruction word; opcode = instr[6:0]
- pc  in  XLEN  PC of instr
- flush  in  1  kill the held entry and any input this cycle
- out_valid  out  1  registered entry valid
- out_ready  in  1  EX stage consumes the entry
- RegWrite, MemWrite, Branch, Jump, JumpReg, ALUSrcB  out  1 each  registered controls
- ImmSrc  out  3  registered control
- ALUSrcA  out  2  registered control: 00 rs1, 01 zero, 10 PC
- ResultSrc, ALUOp  out  2 each  registered controls
- instr_q  out  32  registered instruction
- pc_q  out  XLEN  registered PC
- illegal  out  1  registered entry has an illegal opcode
- ill_count  out  ILL_CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Decode table (opcode: RegWrite ImmSrc ALUSrcA ALUSrcB MemWrite ResultSrc Branch ALUOp Jump JumpReg):
  - lw 0000011: 1 000 00 1 0 01 0 00 0 0
  - sw 0100011: 0 001 00 1 1 00 0 00 0 0
  - R 0110011: 1 000 00 0 0 00 0 10 0 0
  - branch 1100011: 0 010 00 0 0 00 1 01 0 0
  - I-ALU 0010011: 1 000 00 1 0 00 0 10 0 0
  - jal 1101111: 1 011 00 0 0 10 0 00 1 0
  - jalr 1100111: 1 000 00 1 0 10 0 00 0 1
  - lui 0110111: 1 100 01 1 0 00 0 00 0 0
  - auipc 0010111: 1 100 10 1 0 00 0 00 0 0
- No X outputs for any opcode.
- Any other opcode, or a disabled jalr/auipc, is illegal:
  - all controls 0 (bubble encoding);
  - illegal=1.
- in_ready = ~out_valid | out_ready. It is combinational and independent of flush.
- Accept = in_valid & in_ready & ~flush. On accept, the next edge loads the decoded controls, instr_q, pc_q, illegal and sets out_valid=1.
- Consume without accept (out_valid & out_ready & no accept): out_valid goes to 0 and all controls and illegal go to 0 (bubble).
- Stall (out_valid & ~out_ready): all registered outputs hold.
- Flush has priority: next edge gives out_valid=0, all controls and illegal 0, and no accept; the incoming instruction is dropped.
- instr_q and pc_q load only on accept; otherwise they hold.
- Whenever out_valid=0, all control outputs and illegal are 0, so EX sees an all-zero bubble.
- ill_count increments by 1 on each accept whose opcode is illegal. It saturates at 2^ILL_CNT_W-1 and never wraps.
- Latency: 1 cycle from accept to out_valid. Back-to-back throughput is 1 per cycle when out_ready=1.
- Reset (asynchronous, any time including mid-stall):
  - out_valid, all controls, illegal, instr_q, pc_q and ill_count go to 0 immediately;
  - in_ready=1 after reset.

Test Plan:
- Reset then stream lw 0x00002083 and sw 0x00112023 with out_ready=1 -> out_valid high 1 cycle after each accept. Controls are lw 1_000_00_1_0_01_0_00_0_0 then sw 0_001_00_1_1_00_0_00_0_0, with pc_q matching.
- Stall: accept auipc 0x00001097, hold out_ready=0 for 3 cycles with a jalr presented -> in_ready=0, outputs hold auipc (ALUSrcA=10), jalr not accepted. Raising out_ready accepts jalr on that cycle (JumpReg=1 next).
- Flush while a branch is held and lui is presented -> next cycle out_valid=0, all controls 0, lui dropped, ill_count unchanged.
- Illegal opcode 0x0000007F accepted -> illegal=1, controls 0, ill_count 0->1. With ILL_CNT_W=2, five illegals give ill_count=3 (saturated).
- EN_JALR=0: jalr 0x000080E7 -> illegal=1, JumpReg=0.
- Assert reset_n low mid-stall with out_valid=1 -> outputs 0 asynchronously before the next clk edge. After release, in_ready=1.

Source files
------------

// File: rtl/ctrl_decode_reg.sv
// ctrl_decode_reg: RV32I main control decoder with a one-entry ID/EX control register.
// The opcode is decoded combinationally, and the control bundle is registered behind a
// valid/ready handshake. The block also handles flush and detects illegal opcodes.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   ID-stage handshake (in_ready = ~out_valid | out_ready)
//   instr, pc             instruction word and its PC
//   flush                 kill the held entry and drop any input this cycle
//   out_valid / out_ready EX-stage handshake for the held entry
//   RegWrite..JumpReg     registered control bundle (all zero whenever out_valid=0)
//   instr_q, pc_q         registered instruction and PC (load on accept only)
//   illegal               held entry carries an illegal or disabled opcode
//   ill_count             saturating count of accepted illegal instructions
module ctrl_decode_reg #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EN_JALR   = 1'b1,
  parameter bit          EN_AUIPC  = 1'b1,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [XLEN-1:0]      pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 Branch,
  output logic                 Jump,
  output logic                 JumpReg,
  output logic                 ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUOp,
  output logic [31:0]          instr_q,
  output logic [XLEN-1:0]      pc_q,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  // Bundle order: RegWrite ImmSrc[2:0] ALUSrcA[1:0] ALUSrcB MemWrite ResultSrc[1:0]
  //               Branch ALUOp[1:0] Jump JumpReg
  localparam int unsigned CtrlW = 15;

  localparam logic [ILL_CNT_W-1:0] CntMax = {ILL_CNT_W{1'b1}};

  logic [CtrlW-1:0]     w_ctrl;
  logic                 w_illegal;
  logic                 w_accept;

  logic                 r_valid;
  logic [CtrlW-1:0]     r_ctrl;
  logic                 r_illegal;
  logic [31:0]          r_instr;
  logic [XLEN-1:0]      r_pc;
  logic [ILL_CNT_W-1:0] r_ill_count;

  // Opcode decode; unknown or disabled opcodes yield the all-zero bubble plus illegal.
  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    case (instr[6:0])
      OpLw:    w_ctrl = 15'b1_000_00_1_0_01_0_00_0_0;
      OpSw:    w_ctrl = 15'b0_001_00_1_1_00_0_00_0_0;
      OpR:     w_ctrl = 15'b1_000_00_0_0_00_0_10_0_0;
      OpBr:    w_ctrl = 15'b0_010_00_0_0_00_1_01_0_0;
      OpIAlu:  w_ctrl = 15'b1_000_00_1_0_00_0_10_0_0;
      OpJal:   w_ctrl = 15'b1_011_00_0_0_10_0_00_1_0;
      OpLui:   w_ctrl = 15'b1_100_01_1_0_00_0_00_0_0;
      OpJalr: begin
        if (EN_JALR) w_ctrl = 15'b1_000_00_1_0_10_0_00_0_1;
        else         w_illegal = 1'b1;
      end
      OpAuipc: begin
        if (EN_AUIPC) w_ctrl = 15'b1_100_10_1_0_00_0_00_0_0;
        else          w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_illegal   <= 1'b0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_ill_count <= '0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_ctrl    <= w_ctrl;
      r_illegal <= w_illegal;
      r_instr   <= instr;
      r_pc      <= pc;
      if (w_illegal && (r_ill_count != CntMax)) begin
        r_ill_count <= r_ill_count + 1'b1;
      end
    end else if (r_valid && out_ready) begin
      // Consumed with nothing behind it: drop to a bubble.
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign {RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc, Branch, ALUOp, Jump,
          JumpReg} = r_ctrl;
  assign illegal   = r_illegal;
  assign instr_q   = r_instr;
  assign pc_q      = r_pc;
  assign ill_count = r_ill_count;

endmodule
